fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage for the single-cycle RV32I core. Holds the program counter, issues one read per instruction to instruction memory over a request/valid handshake, and latches the returned word. It presents the instruction, its PC and the opcode selector bits [6:2] to the control unit and datapath. It computes the next PC from the control unit's PC-source decision and the datapath's branch/jump target.

## Interface
Parameters:
- XLEN, 32, data/address width
- RESET_PC, 32'h0000_0000, PC loaded on reset

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  read request to instruction memory
- imem_addr  out  XLEN  read address; word aligned
- imem_ready  in  1  memory accepts request this cycle
- imem_rvalid  in  1  read data valid
- imem_rdata  in  XLEN  read data
- pc_src  in  1  1 = take target, 0 = sequential (control unit PCSrc)
- target  in  XLEN  branch/jump target from datapath
- retire  in  1  current instruction completed; advance PC
- instr  out  XLEN  latched instruction
- instr_valid  out  1  instr/pc outputs hold a fetched instruction
- selector  out  5  instr[6:2], to control unit
- pc  out  XLEN  PC of instr
- pc_plus4  out  XLEN  pc + 4 (link value for JAL)
- misalign_err  out  1  sticky misaligned-target flag (macro only; tied 0 otherwise)

## Operation
- FSM states: FETCH, WAIT, HOLD, TRAP (TRAP only with macro).
- FETCH: imem_req=1, imem_addr=pc. On imem_ready go to WAIT; otherwise stay. Address and req stay stable until accepted.
- WAIT: imem_req=0. On imem_rvalid, latch imem_rdata into instr and go to HOLD.
- HOLD: instr_valid=1. On retire, pc <= pc_src ? target : pc+4, then go to FETCH. instr_valid drops the cycle after retire.
- pc+4 wraps modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
- imem_rvalid outside WAIT is ignored. retire outside HOLD is ignored. pc_src and target are sampled only on retire in HOLD.
- Reset values: pc=RESET_PC, state=FETCH, instr=32'h0000_0013 (NOP), instr_valid=0, imem_req=0 while rst_n=0, misalign_err=0. selector and pc_plus4 are derived from instr and pc.
- Reset mid-transaction abandons the access. A response arriving after reset release while in FETCH is dropped.

## Timing
- Request accepted at edge N (imem_ready=1 in FETCH). Earliest imem_rvalid is cycle N+1. instr_valid=1 from the cycle after rvalid is sampled.
- retire sampled at edge M: new pc visible and imem_req=1 in cycle M+1.
- Best-case fetch-to-fetch: 3 cycles plus execute time.
- No combinational path from imem_* inputs to any output.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined:
  - A retire with pc_src=1 and target[1:0]!=0 enters TRAP instead of FETCH.
  - pc is not updated, misalign_err=1 (sticky), instr_valid=0, imem_req=0.
  - Only reset leaves TRAP.
- Undefined: target[1:0] is forced to 00, no TRAP state, misalign_err tied 0.

## Structure
- Shared package riscv_pkg holds: opcode selector constants (5'b00000 load, 5'b00100 OP-IMM, 5'b01000 store, 5'b11000 branch, 5'b01101 LUI, 5'b11011 JAL), the NOP encoding, the default RESET_PC, and the fetch FSM state enum.
- One combinational sub-module, pc_next_sel: pc, pc_src, target -> next_pc, pc_plus4, misalign.

## Test plan
- Reset release, imem_ready=1, rvalid next cycle with 32'h0000_0093 -> imem_addr=0, instr_valid=1, selector=5'b00100, pc=0, pc_plus4=4.
- retire with pc_src=0 at pc=0x10 -> next imem_addr=0x14. Then retire with pc_src=1, target=0x100 -> imem_addr=0x100.
- imem_ready held 0 for 5 cycles -> imem_req and imem_addr=pc stable throughout; no state change.
- pc=32'hFFFF_FFFC, retire, pc_src=0 -> imem_addr=0. Spurious rvalid and retire in FETCH are ignored.
- rst_n asserted while in WAIT -> outputs at reset values immediately; fresh fetch from RESET_PC after release.
- With macro: retire, pc_src=1, target=0x102 -> misalign_err=1, imem_req stays 0, pc unchanged until reset. Without macro: fetch from 0x100.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcode selector values, NOP encoding, default reset PC and the
// fetch FSM state type. Optional feature macro: FETCH_MISALIGN_CHECK_EN adds the trap state.
package riscv_pkg;

  // instr[6:2] selector values seen by the control unit
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    StFetch,
    StWait,
    StHold
`ifdef FETCH_MISALIGN_CHECK_EN
    , StTrap
`endif
  } fetch_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection for the fetch stage: sequential pc+4 or the datapath target.
// The target is always word-aligned on output; misalign reports a taken target whose low
// bits were nonzero so the caller can decide whether to trap.
module pc_next_sel #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic            pc_src,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misalign
);

  // Select the next PC; the add wraps naturally at 2^XLEN
  always_comb begin
    pc_plus4 = pc + XLEN'(4);
    next_pc  = pc_src ? {target[XLEN-1:2], 2'b00} : pc_plus4;
    misalign = pc_src && (target[1:0] != 2'b00);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, performs one request/valid read per instruction and
// presents the latched word until the core retires it.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (trap on a misaligned taken target).
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            pc_src,
  input  logic [XLEN-1:0] target,
  input  logic            retire,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  output logic [4:0]      selector,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misalign_err
);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_q;
  logic            instr_valid_q;
  logic [XLEN-1:0] next_pc;
  logic            misalign;

  pc_next_sel #(
    .XLEN(XLEN)
  ) u_pc_next_sel (
    .pc      (pc_q),
    .pc_src  (pc_src),
    .target  (target),
    .next_pc (next_pc),
    .pc_plus4(pc_plus4),
    .misalign(misalign)
  );

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_err_q;
`else
  logic unused_misalign;
  assign unused_misalign = misalign;
`endif

  // Fetch FSM: request, wait for data, hold until retire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StFetch;
      pc_q          <= RESET_PC;
      instr_q       <= XLEN'(NOP_INSTR);
      instr_valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_err_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        StFetch: begin
          if (imem_ready) state_q <= StWait;
        end
        StWait: begin
          if (imem_rvalid) begin
            instr_q       <= imem_rdata;
            instr_valid_q <= 1'b1;
            state_q       <= StHold;
          end
        end
        StHold: begin
          if (retire) begin
            instr_valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
            if (misalign) begin
              // PC is frozen at the offending instruction; only reset recovers
              misalign_err_q <= 1'b1;
              state_q        <= StTrap;
            end else begin
              pc_q    <= next_pc;
              state_q <= StFetch;
            end
`else
            pc_q    <= next_pc;
            state_q <= StFetch;
`endif
          end
        end
`ifdef FETCH_MISALIGN_CHECK_EN
        StTrap: begin
          state_q <= StTrap;
        end
`endif
        default: state_q <= StFetch;
      endcase
    end
  end

  // Request is held low while reset is asserted even though the state already reads FETCH
  always_comb begin
    imem_req    = rst_n && (state_q == StFetch);
    imem_addr   = pc_q;
    instr       = instr_q;
    instr_valid = instr_valid_q;
    selector    = instr_q[6:2];
    pc          = pc_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    misalign_err = misalign_err_q;
`else
    misalign_err = 1'b0;
`endif
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;
  import riscv_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        pc_src;
  logic [31:0] target;
  logic        retire;
  logic [31:0] instr;
  logic        instr_valid;
  logic [4:0]  selector;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misalign_err;

  int total = 0;
  int bad   = 0;

  fetch_unit #(
    .XLEN    (32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .pc_src      (pc_src),
    .target      (target),
    .retire      (retire),
    .instr       (instr),
    .instr_valid (instr_valid),
    .selector    (selector),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .misalign_err(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // FETCH -> WAIT -> HOLD with data returned the cycle after acceptance
  task automatic do_fetch(input logic [31:0] word);
    imem_ready = 1'b1;
    tick();
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    tick();
    imem_rvalid = 1'b0;
  endtask

  task automatic do_retire(input logic src, input logic [31:0] tgt);
    retire = 1'b1;
    pc_src = src;
    target = tgt;
    tick();
    retire = 1'b0;
    pc_src = 1'b0;
    target = 32'h0;
  endtask

  initial begin
    rst_n       = 1'b0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    pc_src      = 1'b0;
    target      = 32'h0;
    retire      = 1'b0;
    #12;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc4", pc_plus4, 32'h4);
    chk("rst_sel", {27'b0, selector}, {27'b0, OPC_OP_IMM});
    chk("rst_merr", {31'b0, misalign_err}, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rel_req", {31'b0, imem_req}, 32'd1);
    chk("rel_addr", imem_addr, 32'h0);

    // First fetch: addi x1, x0, 0
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    chk("wait_req", {31'b0, imem_req}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0093;
    tick();
    imem_rvalid = 1'b0;
    chk("f0_valid", {31'b0, instr_valid}, 32'd1);
    chk("f0_instr", instr, 32'h0000_0093);
    chk("f0_sel", {27'b0, selector}, {27'b0, OPC_OP_IMM});
    chk("f0_pc", pc, 32'h0);
    chk("f0_pc4", pc_plus4, 32'h4);

    // Jump to 0x10, then sequential
    do_retire(1'b1, 32'h0000_0010);
    chk("j10_addr", imem_addr, 32'h10);
    chk("j10_valid", {31'b0, instr_valid}, 32'd0);
    chk("j10_req", {31'b0, imem_req}, 32'd1);
    do_fetch(32'h0000_2083);
    chk("ld_sel", {27'b0, selector}, {27'b0, OPC_LOAD});
    chk("ld_pc", pc, 32'h10);
    do_retire(1'b0, 32'h0000_0500);
    chk("seq_addr", imem_addr, 32'h14);
    do_fetch(32'h0010_2023);
    chk("st_sel", {27'b0, selector}, {27'b0, OPC_STORE});
    do_retire(1'b1, 32'h0000_0100);
    chk("tgt_addr", imem_addr, 32'h100);

    // Memory stalls for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_req", {31'b0, imem_req}, 32'd1);
      chk("stall_addr", imem_addr, 32'h100);
    end

    // Spurious rvalid and retire in FETCH are ignored
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    retire      = 1'b1;
    pc_src      = 1'b1;
    target      = 32'h0000_0800;
    tick();
    imem_rvalid = 1'b0;
    retire      = 1'b0;
    pc_src      = 1'b0;
    chk("spur_instr", instr, 32'h0010_2023);
    chk("spur_valid", {31'b0, instr_valid}, 32'd0);
    chk("spur_addr", imem_addr, 32'h100);
    chk("spur_req", {31'b0, imem_req}, 32'd1);

    // Retire while waiting for data is ignored
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    retire     = 1'b1;
    tick();
    retire = 1'b0;
    chk("wret_valid", {31'b0, instr_valid}, 32'd0);
    chk("wret_pc", pc, 32'h100);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0063;
    tick();
    imem_rvalid = 1'b0;
    chk("br_sel", {27'b0, selector}, {27'b0, OPC_BRANCH});
    chk("br_valid", {31'b0, instr_valid}, 32'd1);

    // PC wrap
    do_retire(1'b1, 32'hFFFF_FFFC);
    chk("top_addr", imem_addr, 32'hFFFF_FFFC);
    do_fetch(32'h0000_006F);
    chk("jal_sel", {27'b0, selector}, {27'b0, OPC_JAL});
    chk("wrap_pc4", pc_plus4, 32'h0);
    do_retire(1'b0, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);

    // Reset while in WAIT
    do_fetch(32'h1234_5037);
    chk("lui_sel", {27'b0, selector}, {27'b0, OPC_LUI});
    do_retire(1'b1, 32'h0000_0200);
    chk("j200_addr", imem_addr, 32'h200);
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_req", {31'b0, imem_req}, 32'd0);
    chk("mrst_pc", pc, 32'h0);
    chk("mrst_instr", instr, 32'h0000_0013);
    tick();
    rst_n       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0BAD_0BAD;
    tick();
    imem_rvalid = 1'b0;
    chk("late_instr", instr, 32'h0000_0013);
    chk("late_valid", {31'b0, instr_valid}, 32'd0);
    chk("late_req", {31'b0, imem_req}, 32'd1);
    chk("late_addr", imem_addr, 32'h0);

    // Misaligned taken target
    do_fetch(32'h0000_0093);
    do_retire(1'b1, 32'h0000_0102);
`ifdef FETCH_MISALIGN_CHECK_EN
    imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("trap_merr", {31'b0, misalign_err}, 32'd1);
      chk("trap_req", {31'b0, imem_req}, 32'd0);
      chk("trap_pc", pc, 32'h0);
      chk("trap_valid", {31'b0, instr_valid}, 32'd0);
      tick();
    end
    imem_ready = 1'b0;
`else
    chk("mis_addr", imem_addr, 32'h100);
    chk("mis_req", {31'b0, imem_req}, 32'd1);
    chk("mis_merr", {31'b0, misalign_err}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
